// File: rtl/eh2_lsu_trigger_hit_ctl.sv
// eh2_lsu_trigger_hit_ctl
// DC5 stage of the LSU trigger path: registers the DC4 match vector, applies
// per-thread chain pairing and flush kill, keeps per-thread sticky hit status,
// emits breakpoint pulses and runs a per-thread debug-halt request FSM.
// Optional feature macro: LSU_TRIGGER_HITCNT_EN adds per-trigger saturating
// hit counters exported on trigger_hit_cnt.
module eh2_lsu_trigger_hit_ctl #(
  parameter int NUM_THREADS = 2,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  lsu_trigger_match_dc4,
  input  logic                        lsu_tid_dc4,
  input  logic [NUM_THREADS-1:0][1:0] trigger_chain,
  input  logic [NUM_THREADS-1:0][3:0] trigger_action,
  input  logic [NUM_THREADS-1:0]      flush_dc5,
  input  logic [NUM_THREADS-1:0]      mhit_wr_en,
  input  logic [3:0]                  mhit_wr_data,
  output logic [3:0]                  lsu_trigger_hit_dc5,
  output logic                        lsu_trigger_hit_tid_dc5,
  output logic [NUM_THREADS-1:0]      lsu_trigger_bkpt_dc5,
  output logic [NUM_THREADS-1:0]      dbg_halt_req,
  input  logic [NUM_THREADS-1:0]      dbg_halt_ack,
  output logic [NUM_THREADS-1:0][3:0] mhit_status
`ifdef LSU_TRIGGER_HITCNT_EN
  ,
  output logic [3:0][CNT_W-1:0]       trigger_hit_cnt
`endif
);

  typedef enum logic {
    HALT_IDLE = 1'b0,
    HALT_REQ  = 1'b1
  } halt_state_t;

  logic [3:0]                  match_dc5;
  logic                        tid_dc5;
  logic [NUM_THREADS-1:0]      thr_sel;
  logic [1:0]                  sel_chain;
  logic [3:0]                  sel_action;
  logic                        sel_flush;
  logic [3:0]                  chained_hit;
  logic [3:0]                  hit;
  logic                        any_dbg;
  logic                        any_bkpt;
  logic [NUM_THREADS-1:0]      dbg_hit;
  logic [NUM_THREADS-1:0][3:0] status_nxt;
  halt_state_t                 state     [NUM_THREADS];
  halt_state_t                 state_nxt [NUM_THREADS];

  // DC4 -> DC5 pipeline register for the match vector and its thread id.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_dc5 <= 4'b0000;
      tid_dc5   <= 1'b0;
    end else begin
      match_dc5 <= lsu_trigger_match_dc4;
      tid_dc5   <= lsu_tid_dc4;
    end
  end

  // Pick the chain/action/flush controls of the thread owning the DC5 access.
  always_comb begin
    thr_sel    = '0;
    sel_chain  = 2'b00;
    sel_action = 4'b0000;
    sel_flush  = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      thr_sel[t] = (NUM_THREADS == 1) ? 1'b1 : (tid_dc5 == 1'(t));
      if (thr_sel[t]) begin
        sel_chain  = trigger_chain[t];
        sel_action = trigger_action[t];
        sel_flush  = flush_dc5[t];
      end else begin
        sel_chain  = sel_chain;
      end
    end
  end

  // Chain pairing, flush kill and the debug/breakpoint action split.
  always_comb begin
    chained_hit[1:0] = sel_chain[0] ? {2{match_dc5[0] & match_dc5[1]}} : match_dc5[1:0];
    chained_hit[3:2] = sel_chain[1] ? {2{match_dc5[2] & match_dc5[3]}} : match_dc5[3:2];
    hit      = chained_hit & {4{~sel_flush}};
    any_dbg  = |(hit & sel_action);
    any_bkpt = |(hit & ~sel_action);
    dbg_hit              = '0;
    lsu_trigger_bkpt_dc5 = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      dbg_hit[t]              = thr_sel[t] & any_dbg;
      lsu_trigger_bkpt_dc5[t] = thr_sel[t] & any_bkpt & ~any_dbg;
    end
  end

  assign lsu_trigger_hit_dc5     = hit;
  assign lsu_trigger_hit_tid_dc5 = tid_dc5;

  // Halt FSM next state, sticky-status next value and request outputs.
  always_comb begin
    status_nxt   = mhit_status;
    dbg_halt_req = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      state_nxt[t]    = state[t];
      // A hit is OR-ed in after the write so a same-cycle write never drops it.
      status_nxt[t]   = (mhit_wr_en[t] ? mhit_wr_data : mhit_status[t]) |
                        (thr_sel[t] ? hit : 4'b0000);
      dbg_halt_req[t] = (state[t] == HALT_REQ);
      case (state[t])
        HALT_IDLE: begin
          if (dbg_hit[t]) begin
            state_nxt[t] = HALT_REQ;
          end else begin
            state_nxt[t] = HALT_IDLE;
          end
        end
        HALT_REQ: begin
          // Further debug hits here do not queue another request.
          if (dbg_halt_ack[t]) begin
            state_nxt[t] = HALT_IDLE;
          end else begin
            state_nxt[t] = HALT_REQ;
          end
        end
        default: state_nxt[t] = HALT_IDLE;
      endcase
    end
  end

  // Halt FSM state and sticky hit-status registers.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (rst) begin
        state[t]       <= HALT_IDLE;
        mhit_status[t] <= 4'b0000;
      end else begin
        state[t]       <= state_nxt[t];
        mhit_status[t] <= status_nxt[t];
      end
    end
  end

`ifdef LSU_TRIGGER_HITCNT_EN
  // Per-trigger saturating hit counters, shared by all threads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        trigger_hit_cnt[i] <= '0;
      end else if (hit[i] && (trigger_hit_cnt[i] != {CNT_W{1'b1}})) begin
        trigger_hit_cnt[i] <= trigger_hit_cnt[i] + CNT_W'(1);
      end else begin
        trigger_hit_cnt[i] <= trigger_hit_cnt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_eh2_lsu_trigger_hit_ctl.sv
// Scoreboard bench for eh2_lsu_trigger_hit_ctl (NUM_THREADS=2, CNT_W=4).
// The driver predicts each cycle's outputs from a behavioural model and queues
// them; an independent monitor pops and compares every cycle.
module tb_eh2_lsu_trigger_hit_ctl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            match;
  logic                  tid;
  logic [1:0][1:0]       chain;
  logic [1:0][3:0]       action;
  logic [1:0]            flush;
  logic [1:0]            wr_en;
  logic [3:0]            wr_data;
  logic [3:0]            hit_dc5;
  logic                  hit_tid;
  logic [1:0]            bkpt;
  logic [1:0]            req;
  logic [1:0]            ack;
  logic [1:0][3:0]       status;
  logic [3:0][CNT_W-1:0] cnt_out;

  eh2_lsu_trigger_hit_ctl #(.NUM_THREADS(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .lsu_trigger_match_dc4(match), .lsu_tid_dc4(tid),
    .trigger_chain(chain), .trigger_action(action),
    .flush_dc5(flush), .mhit_wr_en(wr_en), .mhit_wr_data(wr_data),
    .lsu_trigger_hit_dc5(hit_dc5), .lsu_trigger_hit_tid_dc5(hit_tid),
    .lsu_trigger_bkpt_dc5(bkpt), .dbg_halt_req(req), .dbg_halt_ack(ack),
    .mhit_status(status)
`ifdef LSU_TRIGGER_HITCNT_EN
    , .trigger_hit_cnt(cnt_out)
`endif
  );

`ifndef LSU_TRIGGER_HITCNT_EN
  assign cnt_out = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  hit;
    logic        tid;
    logic [1:0]  bkpt;
    logic [1:0]  req;
    logic [7:0]  status;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Behavioural model state: what DC5 currently holds and what is sticky.
  logic [3:0]      m_match5;
  logic            m_tid5;
  logic [1:0][3:0] m_status;
  bit              m_req [2];
  int              m_cnt [4];
  // Controls applied from the next cycle on.
  logic [1:0][1:0] chain_v;
  logic [1:0][3:0] action_v;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, expv, $time);
    end
  endtask

  // Monitor: the DUT presents a DC5 result every cycle; compare it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("hit_dc5", 32'(hit_dc5), 32'(e.hit));
        check("hit_tid", 32'(hit_tid), 32'(e.tid));
        check("bkpt",    32'(bkpt),    32'(e.bkpt));
        check("halt_req", 32'(req),    32'(e.req));
        check("mhit_status", 32'(status), 32'(e.status));
`ifdef LSU_TRIGGER_HITCNT_EN
        check("hit_cnt", 32'(cnt_out), 32'(e.cnt));
`endif
      end
    end
  end

  task automatic model_clear();
    m_match5 = 4'b0000;
    m_tid5   = 1'b0;
    m_status = '0;
    for (int i = 0; i < 2; i++) m_req[i] = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // One cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic cyc(input logic r, input logic [3:0] m, input logic t, input logic [1:0] fl,
                     input logic [1:0] we, input logic [3:0] wd, input logic [1:0] ak);
    exp_t       e;
    logic [3:0] ch;
    logic [3:0] h;
    int         th;
    bit         dbg;
    bit         bk;
    @(negedge clk);
    rst = r; match = m; tid = t; flush = fl; wr_en = we; wr_data = wd; ack = ak;
    chain = chain_v; action = action_v;
    th = int'(m_tid5);
    ch = m_match5;
    for (int p = 0; p < 2; p++) begin
      if (chain[th][p]) begin
        ch[2*p]   = m_match5[2*p] & m_match5[2*p+1];
        ch[2*p+1] = ch[2*p];
      end
    end
    h   = fl[th] ? 4'b0000 : ch;
    dbg = |(h & action[th]);
    bk  = |(h & ~action[th]);
    e.hit    = h;
    e.tid    = m_tid5;
    e.bkpt   = 2'b00;
    if (bk && !dbg) e.bkpt[th] = 1'b1;
    e.req    = {1'(m_req[1]), 1'(m_req[0])};
    e.status = m_status;
    for (int i = 0; i < 4; i++) e.cnt[i*4 +: 4] = 4'(m_cnt[i]);
    q.push_back(e);
    if (r) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_status[i] = (we[i] ? wd : m_status[i]) | ((i == th) ? h : 4'b0000);
        if (m_req[i]) m_req[i] = !ak[i];
        else          m_req[i] = (i == th) && dbg;
      end
      for (int i = 0; i < 4; i++)
        if (h[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      m_match5 = m;
      m_tid5   = t;
    end
  endtask

  task automatic idle(input int n, input logic [1:0] ak);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, ak);
  endtask

  initial begin
    rst = 1'b1; match = 4'b0000; tid = 1'b0; flush = 2'b00; wr_en = 2'b00;
    wr_data = 4'b0000; ack = 2'b00; chain = '0; action = '0;
    chain_v = '0; action_v = '0;
    repeat (2) @(posedge clk);
    model_clear();
    idle(2, 2'b00);                                  // reset state
    // Thread 0, no chain, breakpoint action, trigger 2.
    cyc(1'b0, 4'b0100, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(3, 2'b00);
    // Thread 1, chain pair (0,1): single match suppressed, pair match passes.
    chain_v[1] = 2'b01;
    idle(1, 2'b00);
    cyc(1'b0, 4'b0001, 1'b1, 2'b00, 2'b00, 4'b0000, 2'b00);
    cyc(1'b0, 4'b0011, 1'b1, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(3, 2'b00);
    // Thread 0 debug action on trigger 3; repeat hit during REQ; late ack.
    action_v[0] = 4'b1000;
    idle(1, 2'b00);
    cyc(1'b0, 4'b1000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(2, 2'b00);
    cyc(1'b0, 4'b1000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(2, 2'b00);
    idle(1, 2'b01);
    idle(3, 2'b00);
    // Ack already high when the request rises: one-cycle request.
    cyc(1'b0, 4'b1000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b01);
    idle(4, 2'b01);
    // Ack in IDLE is ignored.
    idle(2, 2'b11);
    // Flush kills a thread-0 DC5 debug hit completely.
    cyc(1'b0, 4'b1100, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    cyc(1'b0, 4'b0000, 1'b0, 2'b01, 2'b00, 4'b0000, 2'b00);
    idle(3, 2'b00);
    // Software clear in the same cycle as a new hit keeps the hit.
    action_v = '0;
    cyc(1'b0, 4'b0010, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    cyc(1'b0, 4'b0000, 1'b0, 2'b00, 2'b01, 4'b0000, 2'b00);
    idle(2, 2'b00);
    // Reset while a request is pending.
    action_v[1] = 4'b0001;
    chain_v     = '0;
    cyc(1'b0, 4'b0001, 1'b1, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(2, 2'b00);
    cyc(1'b1, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(3, 2'b00);
    // 20 consecutive trigger-2 hits saturate the counter, then reset.
    action_v = '0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'b0100, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(2, 2'b00);
    cyc(1'b1, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00);
    idle(2, 2'b00);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      chain_v  = 4'($urandom);
      action_v = 8'($urandom);
      cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
          4'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
          ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
          4'($urandom),
          ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
    end
    #5;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #5;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
